// File: rtl/des_perm_pipe.sv
// Elastic DES bit-permutation pipeline: bypass, IP, IP^-1 or half-swap + IP^-1
// applied per 64-bit lane, behind a valid/ready handshake with backpressure.
module des_perm_pipe #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [64*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_mode,
  output logic [64*LANES-1:0]   out_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int unsigned DW   = 64 * LANES;
  localparam int unsigned LAST = PIPE_DEPTH - 1;

  // Table entries are FIPS 46-3 bit numbers: DES bit 1 is lane bit 63.
  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned IPI_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [63:0] permute(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) begin
      if (inv) y[6'(63 - j)] = x[6'(64 - IPI_TAB[j])];
      else     y[6'(63 - j)] = x[6'(64 - IP_TAB[j])];
    end
    return y;
  endfunction

  // Mode 11 swaps halves so L16R16 from the rounds becomes R16L16 before IP^-1.
  function automatic logic [63:0] lane_perm(input logic [63:0] x, input logic [1:0] m);
    logic [63:0] y;
    case (m)
      2'b00:   y = x;
      2'b01:   y = permute(x, 1'b0);
      2'b10:   y = permute(x, 1'b1);
      default: y = permute({x[31:0], x[63:32]}, 1'b1);
    endcase
    return y;
  endfunction

  logic [DW-1:0] w_perm;
  logic          w_adv   [PIPE_DEPTH];
  logic          w_busy;

  logic          r_valid [PIPE_DEPTH];
  logic [DW-1:0] r_data  [PIPE_DEPTH];
  logic [1:0]    r_mode  [PIPE_DEPTH];
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    assign w_perm[64*g +: 64] = lane_perm(in_data[64*g +: 64], in_mode);
  end

  // A stage can load when it or any stage after it is empty, or the sink takes.
  always_comb begin
    for (int s = 0; s < int'(PIPE_DEPTH); s++) begin
      w_adv[s] = out_ready;
      for (int t = s; t < int'(PIPE_DEPTH); t++) begin
        if (!r_valid[t]) w_adv[s] = 1'b1;
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < int'(PIPE_DEPTH); s++) begin
      w_busy = w_busy | r_valid[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int s = 0; s < int'(PIPE_DEPTH); s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_mode[s]  <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_perm;
          r_mode[0] <= in_mode;
        end
      end
      for (int s = 1; s < int'(PIPE_DEPTH); s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= r_valid[s-1];
          if (r_valid[s-1]) begin
            r_data[s] <= r_data[s-1];
            r_mode[s] <= r_mode[s-1];
          end
        end
      end
      if (r_valid[LAST] && out_ready) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = rst_n && w_adv[0];
  assign out_valid = r_valid[LAST];
  assign out_data  = r_data[LAST];
  assign out_mode  = r_mode[LAST];
  assign busy      = w_busy;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: table-derived reference model, random traffic with
// random backpressure, known-answer vectors, stall, mid-stream reset and wrap.
module tb_des_perm_pipe;

  localparam int unsigned LANES = 2;
  localparam int unsigned D     = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned DW    = 64 * LANES;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode  = '0;
  logic [DW-1:0] in_data  = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_mode;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [CW-1:0] beat_cnt;

  logic frc_rdy = 1'b0;
  logic rnd_rdy = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int ip_t  [64];
  int ipi_t [64];

  typedef struct packed {
    logic [1:0]    m;
    logic [DW-1:0] d;
    int unsigned   acc;
  } exp_t;

  exp_t          q[$];
  exp_t          popped;
  logic [CW-1:0] mcnt   = '0;
  int unsigned   edges  = 0;
  int unsigned   dut_hs = 0;
  logic          known  = 1'b0;
  logic          hs_in  = 1'b0;
  logic          hs_out = 1'b0;
  logic          exp_iv, exp_ov;

  des_perm_pipe #(.LANES(LANES), .PIPE_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : frc_rdy;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired before the required event", nm);
  endtask

  // IP rows count down by 8 from 58,60,62,64 then 57,59,61,63; IP^-1 is its inverse.
  task automatic build_tables();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ip_t[8*r+c] = (r < 4) ? (58 + 2*r - 8*c) : (57 + 2*(r-4) - 8*c);
    for (int j = 0; j < 64; j++) ipi_t[ip_t[j]-1] = j + 1;
  endtask

  function automatic logic [63:0] perm64(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    int src;
    y = '0;
    for (int j = 0; j < 64; j++) begin
      src = inv ? ipi_t[j] : ip_t[j];
      y[6'(63 - j)] = x[6'(64 - src)];
    end
    return y;
  endfunction

  function automatic logic [63:0] lane_model(input logic [1:0] m, input logic [63:0] x);
    logic [63:0] y;
    case (m)
      2'b00:   y = x;
      2'b01:   y = perm64(x, 1'b0);
      2'b10:   y = perm64(x, 1'b1);
      default: y = perm64({x[31:0], x[63:32]}, 1'b1);
    endcase
    return y;
  endfunction

  function automatic logic [DW-1:0] beat_model(input logic [1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] y;
    y = '0;
    for (int k = 0; k < int'(LANES); k++)
      y = y | (DW'(lane_model(m, 64'(d >> (64*k)))) << (64*k));
    return y;
  endfunction

  // Reference model: in-order queue of accepted beats; the oldest beat reaches
  // the output D-1 edges after acceptance because nothing is ahead of it.
  initial forever begin
    @(posedge clk);
    edges++;
    if (!rst_n) begin
      q.delete();
      mcnt  = '0;
      known = 1'b1;
    end else if (known) begin
      if (hs_out) begin
        popped = q.pop_front();
        mcnt   = mcnt + CW'(1);
      end
      if (hs_in) q.push_back('{m: in_mode, d: beat_model(in_mode, in_data), acc: edges});
    end
    hs_in  = 1'b0;
    hs_out = 1'b0;
    @(negedge clk);
    if (known) begin
      exp_iv = rst_n && !((q.size() == int'(D)) && !out_ready);
      exp_ov = (q.size() != 0) && (edges >= q[0].acc + D - 1);
      chk("in_ready", 128'(in_ready), 128'(exp_iv));
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      if (exp_ov) begin
        chk("out_data", 128'(out_data), 128'(q[0].d));
        chk("out_mode", 128'(out_mode), 128'(q[0].m));
      end
      chk("busy", 128'(busy), 128'(q.size() != 0));
      chk("beat_cnt", 128'(beat_cnt), 128'(mcnt));
      hs_in  = in_valid && exp_iv;
      hs_out = exp_ov && out_ready;
      if (rst_n && out_valid && out_ready) dut_hs++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [DW-1:0] d);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (n > 200) begin
          fail_to("send_timeout");
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_rdy = 1'b0;
    frc_rdy = 1'b1;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_to("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic kat(input string nm, input logic [1:0] m, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    send(m, d);
    while (!seen && n < 10) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk(nm, 128'(out_data), 128'(exp));
        chk({nm, "_mode"}, 128'(out_mode), 128'(m));
        chk({nm, "_latency"}, 128'(n), 128'(D - 1));
      end else begin
        n++;
      end
    end
    if (!seen) fail_to(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int unsigned base;
    build_tables();

    chk("model_ip", 128'(lane_model(2'b01, 64'h0123456789ABCDEF)), 128'(64'hCC00CCFFF0AAF0AA));
    chk("model_ipinv", 128'(lane_model(2'b10, 64'h0A4CD99543423234)), 128'(64'h85E813540F0AB405));
    chk("model_swap", 128'(lane_model(2'b11, 64'h434232340A4CD995)), 128'(64'h85E813540F0AB405));
    chk("model_inverse", 128'(lane_model(2'b10, 64'hCC00CCFFF0AAF0AA)), 128'(64'h0123456789ABCDEF));

    // Reset held two edges with a beat offered.
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = rnd_data();
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_beat_cnt", 128'(beat_cnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_mode", 128'(out_mode), 128'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    frc_rdy = 1'b1;

    kat("kat_ip", 2'b01, {64'h0123456789ABCDEF, 64'h0123456789ABCDEF},
        {64'hCC00CCFFF0AAF0AA, 64'hCC00CCFFF0AAF0AA});
    kat("kat_ipinv_lanes", 2'b10, {64'hCC00CCFFF0AAF0AA, 64'h0A4CD99543423234},
        {64'h0123456789ABCDEF, 64'h85E813540F0AB405});
    kat("kat_swap_ipinv", 2'b11, {64'h434232340A4CD995, 64'h434232340A4CD995},
        {64'h85E813540F0AB405, 64'h85E813540F0AB405});
    kat("kat_bypass", 2'b00, {64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF},
        {64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF});

    // Fill every stage under stall, then release with a beat offered.
    frc_rdy = 1'b0;
    for (int i = 0; i < int'(D); i++) send(2'($urandom_range(0, 3)), rnd_data());
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = rnd_data();
    @(negedge clk);
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    chk("stall_out_valid", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    frc_rdy = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready), 128'(1));
    chk("release_out_valid", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Random traffic with random backpressure and input gaps.
    base = dut_hs;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(2'($urandom_range(0, 3)), rnd_data());
    end
    drain();
    chk("rand_handshakes", 128'(dut_hs - base), 128'(100));

    // Reset with two beats in flight while the sink is ready.
    frc_rdy = 1'b0;
    send(2'b01, rnd_data());
    send(2'b10, rnd_data());
    in_valid = 1'b1;
    rst_n    = 1'b0;
    frc_rdy  = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_beat_cnt", 128'(beat_cnt), 128'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) send(2'($urandom_range(0, 3)), rnd_data());
    drain();
    chk("wrap_beat_cnt", 128'(beat_cnt), 128'(1));

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
